// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack_ctrl controller: op encoding, FSM states, ID width helper.
package stack_ctrl_pkg;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stack.sv
// Bare LIFO: no overflow/underflow protection; the owner must never push when full or pop when empty.
module stack #(
    parameter int WIDTH = 18,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    localparam int DEPTH = 2 ** SIZE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE:0]    sp;
    logic [SIZE-1:0]  top_idx;

    assign top_idx = sp[SIZE-1:0] - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp       <= '0;
            data_out <= '0;
        end else if (push) begin
            sp <= sp + 1'b1;
        end else if (pop) begin
            sp       <= sp - 1'b1;
            data_out <= mem[top_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[sp[SIZE-1:0]] <= data_in;
    end

endmodule

// File: rtl/stack_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted client; last_gnt moves only on a grant.
module stack_rr_arb
    import stack_ctrl_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [N-1:0]    valid,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] last_gnt
);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] gnt_idx;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = ID_W'((int'(last_gnt) + off) % N);
            if (!found && en && valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_gnt <= ID_W'(N - 1);
        else if (found)
            last_gnt <= gnt_idx;
    end

endmodule

// File: rtl/stack_ctrl.sv
// Multi-requester controller for one stack: RR arbitration, occupancy tracking, tagged 2-cycle responses.
// Optional rejected-op counter port err_count when STACK_CTRL_ERR_CNT_EN is defined.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int STACK_WIDTH = 18,
    parameter int STACK_SIZE  = 4,
    parameter int ID_W        = id_w(N_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_op,
    input  logic [N_REQ*STACK_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [STACK_WIDTH-1:0]       rsp_data,
    output logic                         rsp_err,
    output logic [STACK_SIZE:0]          level,
    output logic                         full,
    output logic                         empty
`ifdef STACK_CTRL_ERR_CNT_EN
    ,
    output logic [15:0]                  err_count
`endif
);
    localparam logic [STACK_SIZE:0] DEPTH_L = (STACK_SIZE + 1)'(2 ** STACK_SIZE);
    localparam int STAGES = 2;

    state_t state, state_nx;
    logic   clr_go, gnt_en;

    logic [N_REQ-1:0]       gnt;
    logic [ID_W-1:0]        last_gnt;
    logic [ID_W-1:0]        sel_id;
    logic                   sel_op;
    logic [STACK_WIDTH-1:0] sel_data;
    logic                   xfer, is_err, ok_push, ok_pop;
    logic [STACK_SIZE:0]    level_nx;

    logic                   stk_rst, stk_push, stk_pop;
    logic [STACK_WIDTH-1:0] stk_din, stk_dout;

    logic [STAGES:1]        vld_pipe;
    logic [ID_W-1:0]        id_s1, id_s2;
    logic                   err_s1, err_s2, pop_s1, pop_s2;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:   if (clear) state_nx = ST_CLEAR;
            ST_CLEAR: state_nx = ST_RUN;
            default:  state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        clr_go = (state == ST_RUN) && clear;
        gnt_en = reset_n && !clr_go;
    end

    stack_rr_arb #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (gnt_en),
        .valid    (req_valid),
        .gnt      (gnt),
        .last_gnt (last_gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_id   = '0;
        sel_op   = OP_POP;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_id   = ID_W'(i);
                sel_op   = req_op[i];
                sel_data = req_data[i*STACK_WIDTH +: STACK_WIDTH];
            end
        end
    end

    // Decisions use the registered level, which already includes last cycle's transfer.
    always_comb begin
        xfer    = |gnt;
        is_err  = xfer && ((sel_op == OP_PUSH) ? full : empty);
        ok_push = xfer && (sel_op == OP_PUSH) && !full;
        ok_pop  = xfer && (sel_op == OP_POP)  && !empty;
        level_nx = level;
        if (clr_go)       level_nx = '0;
        else if (ok_push) level_nx = level + 1'b1;
        else if (ok_pop)  level_nx = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            stk_rst  <= 1'b1;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            stk_din  <= '0;
            vld_pipe <= '0;
            id_s1    <= '0;
            id_s2    <= '0;
            err_s1   <= 1'b0;
            err_s2   <= 1'b0;
            pop_s1   <= 1'b0;
            pop_s2   <= 1'b0;
        end else begin
            level    <= level_nx;
            full     <= (level_nx == DEPTH_L);
            empty    <= (level_nx == '0);
            stk_rst  <= (state_nx == ST_CLEAR);
            stk_push <= ok_push;
            stk_pop  <= ok_pop;
            stk_din  <= sel_data;
            vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
            id_s1    <= sel_id;
            id_s2    <= id_s1;
            err_s1   <= is_err;
            err_s2   <= err_s1;
            pop_s1   <= ok_pop;
            pop_s2   <= pop_s1;
        end
    end

    stack #(.WIDTH(STACK_WIDTH), .SIZE(STACK_SIZE)) u_stack (
        .clk      (clk),
        .reset    (stk_rst),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (stk_din),
        .data_out (stk_dout)
    );

    // Response gated by reset so an op completing during reset is dropped, not reported.
    always_comb begin
        rsp_valid = reset_n && vld_pipe[STAGES];
        rsp_id    = reset_n ? id_s2 : '0;
        rsp_err   = rsp_valid && err_s2;
        rsp_data  = (rsp_valid && pop_s2) ? stk_dout : '0;
    end

`ifdef STACK_CTRL_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n || clr_go)
            err_count <= '0;
        else if (is_err && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a reference model predicts grants, occupancy and queued responses.
module tb_stack_ctrl;
    localparam int NR = 4;
    localparam int W  = 18;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            clear = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_op = '0;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_data;
    logic            rsp_err;
    logic [4:0]      level;
    logic            full, empty;
`ifdef STACK_CTRL_ERR_CNT_EN
    logic [15:0]     err_count;
`endif

    stack_ctrl #(.N_REQ(NR), .STACK_WIDTH(W), .STACK_SIZE(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .level     (level),
        .full      (full),
        .empty     (empty)
`ifdef STACK_CTRL_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        int          err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    int           level_m = 0;
    int           last_m = NR - 1;
    int           err_m = 0;
    logic [W-1:0] sm [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    // One clock: compare at negedge, advance the model for the coming posedge.
    task automatic cycle();
        int          g;
        logic [NR-1:0] exp_rdy;
        exp_t        e;
        @(negedge clk);
        g = -1;
        if (reset_n && !clear)
            for (int off = 1; off <= NR; off++) begin
                int idx;
                idx = (last_m + off) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));

        if (!reset_n) q.delete();
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
        end else begin
            check("rsp_idle", 32'(rsp_valid), 32'd0);
        end

        if (reset_n) begin
            check("level", 32'(level), 32'(level_m));
            check("full", 32'(full), 32'(level_m == 16));
            check("empty", 32'(empty), 32'(level_m == 0));
`ifdef STACK_CTRL_ERR_CNT_EN
            check("err_count", 32'(err_count), 32'(err_m));
`endif
        end

        if (!reset_n) begin
            level_m = 0;
            last_m  = NR - 1;
            err_m   = 0;
        end else if (clear) begin
            level_m = 0;
            err_m   = 0;
        end else if (g >= 0) begin
            last_m = g;
            e.due  = cyc + 2;
            e.id   = g;
            e.err  = 0;
            e.data = '0;
            if (req_op[g]) begin
                if (level_m == 16) e.err = 1;
                else begin
                    sm[level_m] = req_data[g*W +: W];
                    level_m++;
                end
            end else begin
                if (level_m == 0) e.err = 1;
                else begin
                    level_m--;
                    e.data = sm[level_m];
                end
            end
            if (e.err != 0 && err_m != 65535) err_m++;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drv(input int c, input logic op, input logic [W-1:0] d);
        req_valid = '0;
        req_valid[c] = 1'b1;
        req_op[c] = op;
        req_data[c*W +: W] = d;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) cycle();
    endtask

    initial begin
        repeat (3) cycle();
        reset_n = 1'b1;
        idle(1);

        // All clients push together: grants rotate 0,1,2,3,0.
        req_op = '1;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'(32'h100 + i);
        req_valid = '1;
        repeat (5) cycle();
        idle(1);
        repeat (5) begin drv(3, 1'b0, '0); cycle(); end
        idle(3);

        drv(1, 1'b1, 18'h0000A); cycle();
        drv(1, 1'b1, 18'h0000B); cycle();
        drv(2, 1'b0, '0); cycle();
        drv(2, 1'b0, '0); cycle();
        idle(3);

        // Fill past full, then drain past empty.
        for (int i = 0; i < 17; i++) begin drv(0, 1'b1, W'(32'h2000 + i)); cycle(); end
        idle(1);
        for (int i = 0; i < 17; i++) begin drv(0, 1'b0, '0); cycle(); end
        idle(3);

        drv(0, 1'b1, 18'h3FFFF); cycle();
        clear = 1'b1; drv(0, 1'b0, '0); cycle();
        clear = 1'b0; drv(0, 1'b0, '0); cycle();
        idle(4);

        repeat (3) begin drv(1, 1'b0, '0); cycle(); end
        idle(3);
        clear = 1'b1; cycle();
        clear = 1'b0; idle(2);

        // Reset with two ops in flight.
        drv(0, 1'b1, 18'h00005); cycle();
        drv(1, 1'b1, 18'h00006); cycle();
        req_valid = '0;
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        req_valid = '1; req_op = '1;
        cycle();
        idle(4);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
